avmm_rom_responder: RTL and testbench

//   Avalon-MM read-only responder serving 64-bit lines from an internal ROM to a

---
 rtl/avmm_rom_responder.sv | 153 +++++++++++++++
 tb/tb_avmm_rom_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_rom_responder.sv
// Avalon-MM read-only responder serving 64-bit lines from an internal ROM.
// Each command is held off for WAIT_CYCLES cycles, then accepted when fewer
// than MAX_PEND reads are in flight (or one retires in the same cycle).
// Data returns LATENCY cycles after the accept cycle, strictly in order.
// ROM image is built in: line k holds {8{k[7:0]}}; lines past DEPTH read 0.
module avmm_rom_responder #(
    parameter int DEPTH       = 9,
    parameter int LATENCY     = 2,
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_PEND    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic        read,
    output logic        waitrequest,
    output logic [63:0] readdata,
    output logic        readdatavalid,
    output logic [15:0] reads_served,
    output logic        oob_err
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ROM_N  = 1 << IDX_W;
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

    typedef enum logic {IDLE, STALL} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [PEND_W-1:0]  pend_reg;
    logic               stall_done;
    logic               room;
    logic               accept;
    logic               addr_oob;
    logic [63:0]        rom_word;
    logic [63:0]        rom [ROM_N];
    logic [LATENCY-1:0] vld_reg;
    logic [63:0]        dat_reg [LATENCY];

    // ROM contents; power-of-two padding keeps the index in range for any address slice
    genvar gi;
    generate
        for (gi = 0; gi < ROM_N; gi++) begin : g_rom
            if (gi < DEPTH) begin : g_line
                assign rom[gi] = {8{8'(gi)}};
            end else begin : g_pad
                assign rom[gi] = 64'h0;
            end
        end
    endgenerate

    // Out-of-range lines read as zero; the full 32-bit address is compared
    assign addr_oob = (address >= 32'(DEPTH));
    assign rom_word = addr_oob ? 64'h0 : rom[address[IDX_W-1:0]];

    // A retiring read frees its slot in the same cycle, so a full pipe can still stream
    assign room        = (pend_reg < PEND_MAX) | readdatavalid;
    assign accept      = read & stall_done & room;
    assign waitrequest = ~accept;

    // Stall FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Stall FSM next state: count down the wait, then hold stall_done until accepted
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (read) begin
                    if (WAIT_CYCLES == 0) begin
                        stall_done = 1'b1;
                    end else begin
                        state_next = STALL;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            STALL: begin
                if (!read) begin
                    state_next = IDLE;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    stall_done = 1'b1;
                    if (room) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read pipeline: valid shifts every cycle, data only moves with a valid so readdata holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_reg <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_reg[i] <= 64'h0;
            end
        end else begin
            vld_reg[0] <= accept;
            if (accept) begin
                dat_reg[0] <= rom_word;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_reg[i] <= vld_reg[i-1];
                if (vld_reg[i-1]) begin
                    dat_reg[i] <= dat_reg[i-1];
                end
            end
        end
    end

    assign readdatavalid = vld_reg[LATENCY-1];
    assign readdata      = dat_reg[LATENCY-1];

    // Outstanding count, served counter and sticky out-of-range flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_reg     <= '0;
            reads_served <= '0;
            oob_err      <= 1'b0;
        end else begin
            case ({accept, readdatavalid})
                2'b10:   pend_reg <= pend_reg + 1'b1;
                2'b01:   pend_reg <= pend_reg - 1'b1;
                default: pend_reg <= pend_reg;
            endcase
            if (readdatavalid) begin
                reads_served <= reads_served + 16'd1;
            end
            if (accept && addr_oob) begin
                oob_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avmm_rom_responder.sv
// Bench for avmm_rom_responder: a default-configured instance driven through a
// scoreboard, plus two zero-wait instances for back-to-back and wrap behaviour.
module tb_avmm_rom_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        rd0;
    logic [31:0] ad0;
    logic        wr0, rdv0, oob0;
    logic [63:0] data0;
    logic [15:0] served0;

    logic        rd_b   [2];
    logic [31:0] ad_b   [2];
    logic        wr_b   [2];
    logic        rdv_b  [2];
    logic        oob_b  [2];
    logic [63:0] dat_b  [2];
    logic [15:0] srv_b  [2];

    int errors = 0;
    int checks = 0;

    logic [63:0] sb_q [$];
    logic [63:0] mon_exp;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic        oob;
    } vec_t;
    vec_t tv [11];

    avmm_rom_responder #(.DEPTH(9), .LATENCY(2), .WAIT_CYCLES(1), .MAX_PEND(2)) u0 (
        .clk(clk), .reset_n(reset_n), .address(ad0), .read(rd0), .waitrequest(wr0),
        .readdata(data0), .readdatavalid(rdv0), .reads_served(served0), .oob_err(oob0)
    );

    avmm_rom_responder #(.DEPTH(9), .LATENCY(2), .WAIT_CYCLES(0), .MAX_PEND(2)) u1 (
        .clk(clk), .reset_n(reset_n), .address(ad_b[0]), .read(rd_b[0]), .waitrequest(wr_b[0]),
        .readdata(dat_b[0]), .readdatavalid(rdv_b[0]), .reads_served(srv_b[0]), .oob_err(oob_b[0])
    );

    avmm_rom_responder #(.DEPTH(9), .LATENCY(2), .WAIT_CYCLES(0), .MAX_PEND(1)) u2 (
        .clk(clk), .reset_n(reset_n), .address(ad_b[1]), .read(rd_b[1]), .waitrequest(wr_b[1]),
        .readdata(dat_b[1]), .readdatavalid(rdv_b[1]), .reads_served(srv_b[1]), .oob_err(oob_b[1])
    );

    function automatic logic [63:0] rom_image(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        if (a < 32'd9) return {8{b}};
        return 64'h0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every return pulse pops the oldest expected line
    always @(negedge clk) begin
        if (reset_n && rdv0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdv: got pulse data=%h expected no pulse", data0);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("readdata", data0, mon_exp);
                $display("u0 return data=%h expected=%h", data0, mon_exp);
            end
        end
    end

    // Issue one command on u0 and hold it until accepted; returns mid-cycle after the accept
    task automatic do_read0(input logic [31:0] a, input logic [63:0] exp, input bit push);
        bit done;
        done = 1'b0;
        @(negedge clk);
        rd0 = 1'b1;
        ad0 = a;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (!wr0) begin
                if (push) sb_q.push_back(exp);
                done = 1'b1;
                $display("u0 accept addr=%h", a);
            end
            @(negedge clk);
        end
        rd0 = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept for addr %h expected accept within 20 cycles", a);
        end
    endtask

    // Wait until all expected u0 returns are seen, then one more cycle for the counter
    task automatic drain0();
        int c;
        for (c = 0; c < 20 && sb_q.size() != 0; c++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
        #1;
    endtask

    // Four commands held back-to-back on a zero-wait instance
    task automatic burst(input int idx, input int exp_highs, input int exp_span);
        logic [63:0] q [$];
        int acc, highs, rets, first_ret, last_ret;
        acc = 0; highs = 0; rets = 0; first_ret = -1; last_ret = -1;
        @(negedge clk);
        rd_b[idx] = 1'b1;
        ad_b[idx] = 32'd0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (rdv_b[idx]) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL burst_unexpected_rdv: got pulse expected none");
                end else begin
                    chk("burst_data", dat_b[idx], q.pop_front());
                end
                $display("burst%0d return data=%h", idx, dat_b[idx]);
                rets++;
                if (first_ret < 0) first_ret = c;
                last_ret = c;
            end
            if (rd_b[idx]) begin
                if (wr_b[idx]) highs++;
                else begin
                    q.push_back(rom_image(ad_b[idx]));
                    acc++;
                end
            end
            @(negedge clk);
            if (acc == 4) rd_b[idx] = 1'b0;
            else ad_b[idx] = 32'(acc);
        end
        chk("burst_wait_highs", 64'(highs), 64'(exp_highs));
        chk("burst_returns", 64'(rets), 64'd4);
        chk("burst_span", 64'(last_ret - first_ret), 64'(exp_span));
        chk("burst_served", srv_b[idx], 64'd4);
        chk("burst_oob", oob_b[idx], 64'd0);
    endtask

    initial begin
        int acc;
        reset_n = 1'b0;
        rd0 = 1'b0; ad0 = '0;
        for (int i = 0; i < 2; i++) begin
            rd_b[i] = 1'b0;
            ad_b[i] = '0;
        end
        for (int k = 0; k < 9; k++) begin
            tv[k].addr = 32'(k);
            tv[k].data = {8{8'(k)}};
            tv[k].oob  = 1'b0;
        end
        tv[9]  = '{32'd9,           64'h0, 1'b1};
        tv[10] = '{32'h8000_0003,   64'h0, 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_waitrequest", wr0, 1);
        chk("rst_rdv", rdv0, 0);
        chk("rst_readdata", data0, 0);
        chk("rst_served", served0, 0);
        chk("rst_oob", oob0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("idle_waitrequest", wr0, 1);

        // Single read of line 3: one stall cycle, accept, return two cycles later
        @(negedge clk);
        rd0 = 1'b1; ad0 = 32'd3;
        #1 chk("single_stall_wr", wr0, 1);
        @(negedge clk);
        #1 chk("single_accept_wr", wr0, 0);
        sb_q.push_back(64'h0303030303030303);
        @(negedge clk);
        rd0 = 1'b0;
        #1 chk("single_rdv_early", rdv0, 0);
        @(negedge clk);
        #1 chk("single_rdv_on_time", rdv0, 1);
        drain0();

        // Loader pattern 0..8, then two out-of-range addresses
        for (int i = 0; i < 11; i++) begin
            do_read0(tv[i].addr, tv[i].data, 1'b1);
            chk("oob_after_accept", oob0, tv[i].oob);
        end
        drain0();
        chk("served_after_table", served0, 12);
        chk("oob_sticky", oob0, 1);

        // Drop read during STALL: nothing returns and the next command stalls again
        @(negedge clk);
        rd0 = 1'b1; ad0 = 32'd5;
        #1 chk("drop_stall_wr", wr0, 1);
        @(negedge clk);
        rd0 = 1'b0;
        #1 chk("drop_idle_wr", wr0, 1);
        repeat (5) @(negedge clk);
        #1 chk("drop_no_return", served0, 12);
        @(negedge clk);
        rd0 = 1'b1; ad0 = 32'd6;
        #1 chk("restall_wr", wr0, 1);
        @(negedge clk);
        #1 chk("restall_accept_wr", wr0, 0);
        sb_q.push_back(rom_image(32'd6));
        @(negedge clk);
        rd0 = 1'b0;
        drain0();
        chk("served_after_drop", served0, 13);

        // Reset one cycle after an accept: the in-flight read must vanish
        do_read0(32'd4, 64'h0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst_waitrequest", wr0, 1);
        chk("midrst_rdv", rdv0, 0);
        chk("midrst_readdata", data0, 0);
        chk("midrst_served", served0, 0);
        chk("midrst_oob", oob0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1 chk("midrst_no_rdv", rdv0, 0);
        end
        chk("midrst_served_after", served0, 0);

        // Zero-wait streaming: MAX_PEND=2 never stalls, MAX_PEND=1 stalls every other cycle
        burst(0, 0, 3);
        burst(1, 3, 6);

        // 65536 back-to-back reads wrap the served counter to zero
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd_b[0] = 1'b1;
        ad_b[0] = 32'd2;
        acc = 0;
        for (int c = 0; c < 70000 && acc < 65536; c++) begin
            #1;
            if (!wr_b[0]) acc++;
            @(negedge clk);
        end
        rd_b[0] = 1'b0;
        $display("wrap run accepted=%0d", acc);
        chk("wrap_accepts", 64'(acc), 64'd65536);
        repeat (5) @(negedge clk);
        #1;
        chk("wrap_served", srv_b[0], 0);
        chk("wrap_last_data", dat_b[0], 64'h0202020202020202);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
